regalu_phase_ctrl: RTL and testbench

//  Sequencer for the register-array/ALU top (RegATop-style datapath).

---
 rtl/regalu_phase_ctrl_if.sv | 33 +++
 rtl/regalu_phase_ctrl.sv | 166 ++++++++++++++++
 tb/tb_regalu_phase_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regalu_phase_ctrl_if.sv
// Request and datapath-control bundle between a requester and the regalu phase sequencer.
// The master drives requests; the slave (sequencer) drives latched fields and phase strobes.
interface regalu_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr_a;
  logic [4:0] req_addr_b;
  logic [4:0] req_waddr;
  logic [3:0] req_alu_op;
  logic       req_wen;
  logic [4:0] R_Addr_A;
  logic [4:0] R_Addr_B;
  logic [4:0] W_Addr;
  logic [3:0] ALU_OP;
  logic       Reg_Write;
  logic       clk_RR;
  logic       clk_F;
  logic       clk_WB;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_addr_a, req_addr_b, req_waddr, req_alu_op, req_wen,
    input  req_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           clk_RR, clk_F, clk_WB, busy, done
  );

  modport slave (
    input  req_valid, req_addr_a, req_addr_b, req_waddr, req_alu_op, req_wen,
    output req_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           clk_RR, clk_F, clk_WB, busy, done
  );
endinterface

// File: rtl/regalu_phase_ctrl.sv
// Phase sequencer for the register-array/ALU datapath: one request -> RR, F, optional WB strobes, then done.
// Defining STEP_MODE_EN adds the step port; each phase then starts only on a step rising edge.
module regalu_phase_ctrl #(
  parameter int PHASE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef STEP_MODE_EN
  input  logic step,
`endif
  regalu_phase_ctrl_if.slave bus
);

  localparam int MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_RR, S_F, S_WB, S_DONE} state_t;

  state_t        state;
  state_t        next_phase;
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          wen_q;
  logic [2:0]    strobe_q;
  logic          done_q;
  logic          busy_q;
  logic          ready_q;
  logic          regw_q;
  logic [4:0]    addr_a_q;
  logic [4:0]    addr_b_q;
  logic [4:0]    waddr_q;
  logic [3:0]    alu_op_q;
  logic          step_edge;

`ifdef STEP_MODE_EN
  localparam bit STEP_MODE = 1'b1;
  logic step_s1;
  logic step_s2;
  logic step_d;

  // Two-flop synchroniser plus delay flop so a held-high step yields a single advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  assign step_edge = step_s2 & ~step_d;
`else
  localparam bit STEP_MODE = 1'b0;
  assign step_edge = 1'b0;
`endif

  function automatic logic [2:0] strobe_of(input state_t s);
    case (s)
      S_RR:    return 3'b001;
      S_F:     return 3'b010;
      S_WB:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    next_phase = S_DONE;
    if (state == S_RR)
      next_phase = S_F;
    else if (state == S_F && wen_q)
      next_phase = S_WB;
  end

  // Within a phase, a non-zero strobe marks the high part and a zero strobe the gap;
  // cnt counts the remaining cycles of whichever part is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      waiting  <= 1'b0;
      wen_q    <= 1'b0;
      strobe_q <= 3'b000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      regw_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      waddr_q  <= '0;
      alu_op_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_a_q <= bus.req_addr_a;
            addr_b_q <= bus.req_addr_b;
            waddr_q  <= bus.req_waddr;
            alu_op_q <= bus.req_alu_op;
            wen_q    <= bus.req_wen;
            state    <= S_RR;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            cnt      <= PHASE_LOAD;
            waiting  <= STEP_MODE;
            strobe_q <= STEP_MODE ? 3'b000 : 3'b001;
          end
        end
        S_RR, S_F, S_WB: begin
          if (waiting) begin
            if (step_edge) begin
              waiting  <= 1'b0;
              strobe_q <= strobe_of(state);
              cnt      <= PHASE_LOAD;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (strobe_q != 3'b000 && (GAP_CYC > 0)) begin
            strobe_q <= 3'b000;
            cnt      <= GAP_LOAD;
          end else begin
            state    <= next_phase;
            regw_q   <= (next_phase == S_WB);
            cnt      <= PHASE_LOAD;
            waiting  <= STEP_MODE;
            strobe_q <= STEP_MODE ? 3'b000 : strobe_of(next_phase);
            done_q   <= !STEP_MODE && (next_phase == S_DONE);
          end
        end
        S_DONE: begin
          if (waiting) begin
            if (step_edge) begin
              waiting <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            regw_q  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.R_Addr_A  = addr_a_q;
  assign bus.R_Addr_B  = addr_b_q;
  assign bus.W_Addr    = waddr_q;
  assign bus.ALU_OP    = alu_op_q;
  assign bus.Reg_Write = regw_q;
  assign bus.clk_RR    = strobe_q[0];
  assign bus.clk_F     = strobe_q[1];
  assign bus.clk_WB    = strobe_q[2];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regalu_phase_ctrl.sv
// Bench for regalu_phase_ctrl: two instances (1/1 and 3/0 phase/gap timing) checked against
// a cycle-indexed waveform model derived from the phase arithmetic.
module tb_regalu_phase_ctrl;

  typedef struct packed {
    logic       rr;
    logic       f;
    logic       wb;
    logic       regw;
    logic       done;
    logic       busy;
    logic       ready;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] w;
    logic [3:0] op;
  } obs_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
`ifdef STEP_MODE_EN
  logic step0;
  logic step1;
`endif

  regalu_phase_ctrl_if bus0();
  regalu_phase_ctrl_if bus1();

  regalu_phase_ctrl #(.PHASE_CYC(1), .GAP_CYC(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef STEP_MODE_EN
    .step  (step0),
`endif
    .bus   (bus0)
  );

  regalu_phase_ctrl #(.PHASE_CYC(3), .GAP_CYC(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef STEP_MODE_EN
    .step  (step1),
`endif
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample(input int sel);
    if (sel == 0)
      return {bus0.clk_RR, bus0.clk_F, bus0.clk_WB, bus0.Reg_Write, bus0.done, bus0.busy,
              bus0.req_ready, bus0.R_Addr_A, bus0.R_Addr_B, bus0.W_Addr, bus0.ALU_OP};
    return {bus1.clk_RR, bus1.clk_F, bus1.clk_WB, bus1.Reg_Write, bus1.done, bus1.busy,
            bus1.req_ready, bus1.R_Addr_A, bus1.R_Addr_B, bus1.W_Addr, bus1.ALU_OP};
  endfunction

  // Reference: an op is a sequence of equal-length phases, each strobe-then-gap, then one done cycle.
  function automatic obs_t model(input int p, input int g, input logic wen, input int cyc,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] w, input logic [3:0] op);
    obs_t e;
    int   last;
    int   k;
    e    = '0;
    e.a  = a;
    e.b  = b;
    e.w  = w;
    e.op = op;
    last = (wen ? 3 : 2) * (p + g);
    if (cyc < last) begin
      k      = cyc / (p + g);
      e.busy = 1'b1;
      e.regw = (k == 2);
      if ((cyc % (p + g)) < p) begin
        if (k == 0)      e.rr = 1'b1;
        else if (k == 1) e.f  = 1'b1;
        else             e.wb = 1'b1;
      end
    end else if (cyc == last) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else begin
      e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic start_op(input int sel, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] w, input logic [3:0] op, input logic wen);
    if (sel == 0) begin
      bus0.req_addr_a = a; bus0.req_addr_b = b; bus0.req_waddr = w;
      bus0.req_alu_op = op; bus0.req_wen = wen; bus0.req_valid = 1'b1;
    end else begin
      bus1.req_addr_a = a; bus1.req_addr_b = b; bus1.req_waddr = w;
      bus1.req_alu_op = op; bus1.req_wen = wen; bus1.req_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      bus0.req_valid = 1'b0; bus0.req_addr_a = 5'($urandom); bus0.req_addr_b = 5'($urandom);
      bus0.req_waddr = 5'($urandom); bus0.req_alu_op = 4'($urandom); bus0.req_wen = 1'($urandom);
    end else begin
      bus1.req_valid = 1'b0; bus1.req_addr_a = 5'($urandom); bus1.req_addr_b = 5'($urandom);
      bus1.req_waddr = 5'($urandom); bus1.req_alu_op = 4'($urandom); bus1.req_wen = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    want       = '0;
    want.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      for (int sel = 0; sel < 2; sel++) begin
        got = sample(sel);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL reset dut%0d step%0d got=%h want=%h", sel, i, got, want);
        end
      end
    end
  endtask

  task automatic test_sequencing();
    obs_t got;
    obs_t want;
    for (int t = 0; t < 20; t++) begin
      int         sel;
      int         p;
      int         g;
      int         last;
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] w;
      logic [3:0] op;
      logic       wen;
      case (t)
        0: begin sel = 0; a = 5'd3; b = 5'd5;  w = 5'd7;  op = 4'h2; wen = 1'b1; end
        1: begin sel = 0; a = 5'd3; b = 5'd5;  w = 5'd7;  op = 4'h2; wen = 1'b0; end
        2: begin sel = 1; a = 5'd9; b = 5'd10; w = 5'd11; op = 4'hC; wen = 1'b1; end
        default: begin
          sel = int'($urandom_range(0, 1));
          a   = 5'($urandom); b = 5'($urandom); w = 5'($urandom);
          op  = 4'($urandom); wen = 1'($urandom);
        end
      endcase
      p    = (sel == 0) ? 1 : 3;
      g    = (sel == 0) ? 1 : 0;
      last = (wen ? 3 : 2) * (p + g);
      start_op(sel, a, b, w, op, wen);
      for (int c = 0; c <= last + 1; c++) begin
        @(negedge clk);
        got  = sample(sel);
        want = model(p, g, wen, c, a, b, w, op);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL seq op%0d dut%0d cyc%0d got=%h want=%h", t, sel, c, got, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t       got;
    obs_t       want;
    logic [4:0] a  [2] = '{5'd1, 5'd17};
    logic [4:0] b  [2] = '{5'd2, 5'd18};
    logic [4:0] w  [2] = '{5'd3, 5'd19};
    logic [3:0] op [2] = '{4'h9, 4'h6};
    logic       wen[2] = '{1'b1, 1'b0};
    start_op(0, a[0], b[0], w[0], op[0], wen[0]);
    for (int n = 0; n < 2; n++) begin
      int last;
      last = (wen[n] ? 3 : 2) * 2;
      for (int c = 0; c <= last + 1; c++) begin
        @(negedge clk);
        got  = sample(0);
        want = model(1, 1, wen[n], c, a[n], b[n], w[n], op[n]);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL b2b op%0d cyc%0d got=%h want=%h", n, c, got, want);
        end
        if (n == 0 && c == 2) begin
          bus0.req_addr_a = a[1]; bus0.req_addr_b = b[1]; bus0.req_waddr = w[1];
          bus0.req_alu_op = op[1]; bus0.req_wen = wen[1]; bus0.req_valid = 1'b1;
        end
      end
      if (n == 0) begin
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t got;
    obs_t want;
    start_op(0, 5'd4, 5'd6, 5'd8, 4'h3, 1'b1);
    repeat (3) @(negedge clk);
    got = sample(0);
    vectors++;
    if (got.f !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_pre clk_F got=%b want=1", got.f);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    want       = '0;
    want.ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = sample(0);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL abort cyc%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

`ifdef STEP_MODE_EN
  task automatic test_step();
    obs_t got;
    obs_t want;
    bit   seen;
    start_op(0, 5'd3, 5'd5, 5'd7, 4'h2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        got = sample(0);
        vectors++;
        if ({got.rr, got.f, got.wb, got.done, got.busy} !== 5'b00001) begin
          miscompares++;
          $display("[TB] FAIL step_hold k%0d i%0d got=%h", k, i, got);
        end
      end
      step0 = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge clk);
        got  = sample(0);
        seen = (k == 0) ? got.rr : (k == 1) ? got.f : (k == 2) ? got.wb : got.done;
      end
      step0 = 1'b0;
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("[TB] FAIL step_advance k%0d got=0 want=1", k);
      end
    end
    @(negedge clk);
    got        = sample(0);
    want       = '0;
    want.ready = 1'b1;
    want.a     = 5'd3;
    want.b     = 5'd5;
    want.w     = 5'd7;
    want.op    = 4'h2;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL step_end got=%h want=%h", got, want);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_addr_a = '0; bus0.req_addr_b = '0;
    bus0.req_waddr = '0;   bus0.req_alu_op = '0; bus0.req_wen = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_addr_a = '0; bus1.req_addr_b = '0;
    bus1.req_waddr = '0;   bus1.req_alu_op = '0; bus1.req_wen = 1'b0;
`ifdef STEP_MODE_EN
    step0 = 1'b0;
    step1 = 1'b0;
`endif
    test_reset();
`ifdef STEP_MODE_EN
    test_step();
`else
    test_sequencing();
    test_back_to_back();
    test_reset_mid_op();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
